// File: rtl/rvx_core_load_store_unit_pkg.sv
// Shared encodings and store-lane helpers for the
// rvx core load/store unit.
package rvx_core_load_store_unit_pkg;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_REQ  = 2'd1,
    ST_WAIT = 2'd2,
    ST_DONE = 2'd3
  } lsu_state_e;

  localparam logic [2:0] F3_B  = 3'b000;
  localparam logic [2:0] F3_H  = 3'b001;
  localparam logic [2:0] F3_W  = 3'b010;
  localparam logic [2:0] F3_BU = 3'b100;
  localparam logic [2:0] F3_HU = 3'b101;

  localparam logic [3:0] STRB_B = 4'b0001;
  localparam logic [3:0] STRB_H = 4'b0011;
  localparam logic [3:0] STRB_W = 4'b1111;

  // size is funct3[1:0]: 00 byte, 01 half, else word
  function automatic logic [3:0] store_strobe(
    input logic [1:0] size,
    input logic [1:0] a
  );
    case (size)
      2'b00:   return STRB_B << a;
      2'b01:   return STRB_H << {a[1], 1'b0};
      default: return STRB_W;
    endcase
  endfunction

  function automatic logic [31:0] store_data(
    input logic [1:0]  size,
    input logic [31:0] rs2
  );
    case (size)
      2'b00:   return {4{rs2[7:0]}};
      2'b01:   return {2{rs2[15:0]}};
      default: return rs2;
    endcase
  endfunction

endpackage

// File: rtl/rvx_core_load_formatter.sv
// Load result formatter: lane shift by byte offset,
// then sign or zero extension by access size.
module rvx_core_load_formatter
  import rvx_core_load_store_unit_pkg::*;
(
  input  logic [2:0]  i_funct3,
  input  logic [1:0]  i_addr_lo,
  input  logic [31:0] i_read_data,
  output logic [31:0] o_load_data
);

  logic [31:0] w_shift;

  assign w_shift = i_read_data >> {i_addr_lo, 3'b000};

  always_comb begin
    o_load_data = w_shift;
    case (i_funct3)
      F3_B:    o_load_data = {{24{w_shift[7]}}, w_shift[7:0]};
      F3_H:    o_load_data = {{16{w_shift[15]}}, w_shift[15:0]};
      F3_BU:   o_load_data = {24'b0, w_shift[7:0]};
      F3_HU:   o_load_data = {16'b0, w_shift[15:0]};
      default: o_load_data = w_shift;
    endcase
  end

endmodule

// File: rtl/rvx_core_load_store_unit.sv
// Stage-1 load/store sequencer: one bus transaction per
// access, stalls the pipe until completion or timeout.
module rvx_core_load_store_unit
  import rvx_core_load_store_unit_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 255,
  parameter int unsigned TIMEOUT_WIDTH  = 8
) (
  input  logic        clock,
  input  logic        reset_n,
  input  logic        load_s1,
  input  logic        store_s1,
  input  logic [2:0]  funct3_s1,
  input  logic [31:0] target_address_s1,
  input  logic [31:0] rs2_data_s1,
  input  logic        misaligned_load_s1,
  input  logic        misaligned_store_s1,
  input  logic        flush,
  output logic [31:0] bus_address,
  output logic        bus_read_request,
  output logic        bus_write_request,
  output logic [31:0] bus_write_data,
  output logic [3:0]  bus_write_strobe,
  input  logic        bus_ready,
  input  logic        bus_response,
  input  logic [31:0] bus_read_data,
  output logic        stall_s1,
  output logic [31:0] load_data,
  output logic        load_data_valid,
  output logic        access_fault
);

  localparam bit L_TO_EN = TIMEOUT_CYCLES != 0;
  localparam logic [TIMEOUT_WIDTH-1:0] L_LIMIT =
    TIMEOUT_WIDTH'(L_TO_EN ? TIMEOUT_CYCLES - 1 : 0);

  lsu_state_e r_state;
  lsu_state_e w_state_nxt;

  logic [31:0]              r_addr;
  logic [31:0]              r_wdata;
  logic [31:0]              r_load_data;
  logic [3:0]               r_strobe;
  logic [2:0]               r_funct3;
  logic                     r_is_load;
  logic                     r_fault;
  logic                     r_cancel;
  logic [TIMEOUT_WIDTH-1:0] r_count;

  logic        w_start;
  logic        w_in_bus;
  logic        w_complete;
  logic        w_timeout;
  logic [31:0] w_fmt;

  assign w_start = (load_s1 | store_s1) & ~misaligned_load_s1
                 & ~misaligned_store_s1 & ~flush;
  assign w_in_bus = (r_state == ST_REQ) | (r_state == ST_WAIT);
  assign w_complete =
      ((r_state == ST_REQ) & bus_ready & bus_response)
    | ((r_state == ST_WAIT) & bus_response);
  // a response on the limit cycle wins over the timeout
  assign w_timeout = L_TO_EN & w_in_bus
                   & (r_count == L_LIMIT) & ~w_complete;

  rvx_core_load_formatter u_fmt (
    .i_funct3   (r_funct3),
    .i_addr_lo  (r_addr[1:0]),
    .i_read_data(bus_read_data),
    .o_load_data(w_fmt)
  );

  always_comb begin
    w_state_nxt = r_state;
    unique case (r_state)
      ST_IDLE: if (w_start) w_state_nxt = ST_REQ;
      ST_REQ: begin
        if (w_complete | w_timeout) w_state_nxt = ST_DONE;
        else if (bus_ready)         w_state_nxt = ST_WAIT;
      end
      ST_WAIT: if (w_complete | w_timeout) w_state_nxt = ST_DONE;
      ST_DONE: w_state_nxt = ST_IDLE;
    endcase
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      r_state     <= ST_IDLE;
      r_addr      <= '0;
      r_wdata     <= '0;
      r_load_data <= '0;
      r_strobe    <= '0;
      r_funct3    <= '0;
      r_is_load   <= 1'b0;
      r_fault     <= 1'b0;
      r_cancel    <= 1'b0;
      r_count     <= '0;
    end else begin
      r_state <= w_state_nxt;
      if ((r_state == ST_IDLE) && w_start) begin
        r_addr    <= target_address_s1;
        r_strobe  <= store_strobe(funct3_s1[1:0],
                                  target_address_s1[1:0]);
        r_wdata   <= store_data(funct3_s1[1:0], rs2_data_s1);
        r_funct3  <= funct3_s1;
        r_is_load <= load_s1;
        r_count   <= '0;
        r_fault   <= 1'b0;
        r_cancel  <= 1'b0;
      end
      if (w_in_bus) begin
        r_count <= r_count + 1'b1;
        if (w_timeout) r_fault  <= 1'b1;
        if (flush)     r_cancel <= 1'b1;
        if (w_complete & r_is_load & ~r_cancel & ~flush)
          r_load_data <= w_fmt;
      end
    end
  end

  assign stall_s1 = ((r_state == ST_IDLE) & w_start) | w_in_bus;
  assign bus_address       = {r_addr[31:2], 2'b00};
  assign bus_read_request  = (r_state == ST_REQ) & r_is_load;
  assign bus_write_request = (r_state == ST_REQ) & ~r_is_load;
  assign bus_write_data    = r_wdata;
  assign bus_write_strobe  = r_strobe;
  assign load_data         = r_load_data;
  assign load_data_valid   = (r_state == ST_DONE) & r_is_load
                           & ~r_fault & ~r_cancel;
  assign access_fault      = (r_state == ST_DONE) & r_fault
                           & ~r_cancel;

endmodule

// File: tb/tb_rvx_core_load_store_unit.sv
// Directed bench for the load/store unit with a
// transaction-level expectation model.
module tb_rvx_core_load_store_unit;

  localparam int T = 4;

  logic        clock = 1'b0;
  logic        reset_n = 1'b0;
  logic        load_s1 = 1'b0;
  logic        store_s1 = 1'b0;
  logic [2:0]  funct3_s1 = '0;
  logic [31:0] target_address_s1 = '0;
  logic [31:0] rs2_data_s1 = '0;
  logic        misaligned_load_s1 = 1'b0;
  logic        misaligned_store_s1 = 1'b0;
  logic        flush = 1'b0;
  logic [31:0] bus_address;
  logic        bus_read_request;
  logic        bus_write_request;
  logic [31:0] bus_write_data;
  logic [3:0]  bus_write_strobe;
  logic        bus_ready = 1'b0;
  logic        bus_response = 1'b0;
  logic [31:0] bus_read_data = '0;
  logic        stall_s1;
  logic [31:0] load_data;
  logic        load_data_valid;
  logic        access_fault;

  always #5 clock = ~clock;

  rvx_core_load_store_unit #(
    .TIMEOUT_CYCLES(T),
    .TIMEOUT_WIDTH (8)
  ) dut (
    .clock              (clock),
    .reset_n            (reset_n),
    .load_s1            (load_s1),
    .store_s1           (store_s1),
    .funct3_s1          (funct3_s1),
    .target_address_s1  (target_address_s1),
    .rs2_data_s1        (rs2_data_s1),
    .misaligned_load_s1 (misaligned_load_s1),
    .misaligned_store_s1(misaligned_store_s1),
    .flush              (flush),
    .bus_address        (bus_address),
    .bus_read_request   (bus_read_request),
    .bus_write_request  (bus_write_request),
    .bus_write_data     (bus_write_data),
    .bus_write_strobe   (bus_write_strobe),
    .bus_ready          (bus_ready),
    .bus_response       (bus_response),
    .bus_read_data      (bus_read_data),
    .stall_s1           (stall_s1),
    .load_data          (load_data),
    .load_data_valid    (load_data_valid),
    .access_fault       (access_fault)
  );

  int n_checks = 0;
  int n_fail = 0;

  bit          chk_en = 0;
  logic        e_stall = 0, e_rreq = 0, e_wreq = 0;
  logic        e_valid = 0, e_fault = 0, e_lanes = 0;
  logic [31:0] e_addr = '0, e_wdata = '0, e_ld = '0;
  logic [3:0]  e_strb = '0;

  task automatic check(input string name,
                       input logic [31:0] act,
                       input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %h expected %h at %0t",
               name, act, exp, $time);
    end
  endtask

  function automatic logic [31:0] m_load(input logic [2:0] f3,
                                         input logic [1:0] a,
                                         input logic [31:0] rd);
    logic [31:0] v;
    v = rd >> (8 * a);
    case (f3)
      3'b000: return 32'($signed(v[7:0]));
      3'b001: return 32'($signed(v[15:0]));
      3'b100: return 32'(v[7:0]);
      3'b101: return 32'(v[15:0]);
      default: return v;
    endcase
  endfunction

  function automatic logic [3:0] m_strobe(input logic [2:0] f3,
                                          input logic [1:0] a);
    if (f3[1:0] == 2'b00) return 4'(1 << a);
    if (f3[1:0] == 2'b01) return a[1] ? 4'b1100 : 4'b0011;
    return 4'b1111;
  endfunction

  function automatic logic [31:0] m_wdata(input logic [2:0] f3,
                                          input logic [31:0] rs2);
    if (f3[1:0] == 2'b00) return {4{rs2[7:0]}};
    if (f3[1:0] == 2'b01) return {2{rs2[15:0]}};
    return rs2;
  endfunction

  always @(negedge clock) begin
    if (chk_en) begin
      check("stall_s1", stall_s1, e_stall);
      check("bus_read_request", bus_read_request, e_rreq);
      check("bus_write_request", bus_write_request, e_wreq);
      check("load_data_valid", load_data_valid, e_valid);
      check("access_fault", access_fault, e_fault);
      check("load_data", load_data, e_ld);
      if (e_lanes) check("bus_address", bus_address, e_addr);
      if (e_lanes && e_wreq) begin
        check("bus_write_strobe", bus_write_strobe, e_strb);
        check("bus_write_data", bus_write_data, e_wdata);
      end
    end
  end

  // rdy/rsp/fl: REQ/WAIT cycle index of ready, response, flush (-1 none)
  task automatic access(input bit is_ld, input logic [2:0] f3,
                        input logic [31:0] addr, input logic [31:0] rs2,
                        input logic [31:0] rd,
                        input int rdy, input int rsp, input int fl,
                        output logic [31:0] got_ld,
                        output logic [31:0] got_addr,
                        output logic [3:0]  got_strb,
                        output logic [31:0] got_wd);
    int c, last, rq_last;
    bit flt, cancel;
    c = 1000;
    if (rdy >= 0) begin
      if (rsp == rdy) c = rdy;
      else if (rsp > rdy) c = rsp;
    end
    if (c <= T - 1) begin last = c; flt = 0; end
    else begin last = T - 1; flt = 1; end
    rq_last = (rdy >= 0 && rdy < last) ? rdy : last;
    cancel = (fl >= 0 && fl <= last);
    got_addr = '0; got_strb = '0; got_wd = '0;

    load_s1 = is_ld; store_s1 = !is_ld; funct3_s1 = f3;
    target_address_s1 = addr; rs2_data_s1 = rs2;
    bus_read_data = rd;
    e_stall = 1; e_rreq = 0; e_wreq = 0; e_lanes = 0;
    e_valid = 0; e_fault = 0;
    for (int k = 0; k <= last; k++) begin
      @(posedge clock); #1;
      bus_ready = (k == rdy);
      bus_response = (k == rsp);
      flush = (k == fl);
      e_stall = 1;
      e_rreq = is_ld && k <= rq_last;
      e_wreq = !is_ld && k <= rq_last;
      e_lanes = k <= rq_last;
      e_addr = {addr[31:2], 2'b00};
      e_strb = m_strobe(f3, addr[1:0]);
      e_wdata = m_wdata(f3, rs2);
      if (k == 0) begin
        got_addr = bus_address;
        got_strb = bus_write_strobe;
        got_wd = bus_write_data;
      end
    end
    @(posedge clock); #1;
    bus_ready = 0; bus_response = 0; flush = 0;
    e_stall = 0; e_rreq = 0; e_wreq = 0; e_lanes = 0;
    e_valid = is_ld && !flt && !cancel;
    e_fault = flt && !cancel;
    if (e_valid) e_ld = m_load(f3, addr[1:0], rd);
    got_ld = load_data;
    @(posedge clock); #1;
    load_s1 = 0; store_s1 = 0;
    e_valid = 0; e_fault = 0; e_stall = 0;
  endtask

  logic [31:0] g_ld, g_addr, g_wd;
  logic [3:0]  g_strb;

  initial begin
    repeat (2) @(posedge clock);
    #1 reset_n = 1;
    check("reset bus_address", bus_address, 32'h0);
    check("reset write_data", bus_write_data, 32'h0);
    check("reset strobe", bus_write_strobe, 4'h0);
    check("reset load_data", load_data, 32'h0);
    check("reset stall", stall_s1, 1'b0);
    chk_en = 1;
    @(posedge clock); #1;

    access(0, 3'b010, 32'h00001004, 32'hDEADBEEF, 32'h0,
           2, 3, -1, g_ld, g_addr, g_strb, g_wd);
    check("sw address", g_addr, 32'h00001004);
    check("sw strobe", g_strb, 4'b1111);
    check("sw data", g_wd, 32'hDEADBEEF);

    access(1, 3'b000, 32'h00002003, 32'h0, 32'h80FFFFFF,
           0, 0, -1, g_ld, g_addr, g_strb, g_wd);
    check("lb data", g_ld, 32'hFFFFFF80);
    check("lb address", g_addr, 32'h00002000);
    access(1, 3'b100, 32'h00002003, 32'h0, 32'h80FFFFFF,
           0, 0, -1, g_ld, g_addr, g_strb, g_wd);
    check("lbu data", g_ld, 32'h00000080);

    access(0, 3'b001, 32'h00000002, 32'h1234ABCD, 32'h0,
           0, 1, -1, g_ld, g_addr, g_strb, g_wd);
    check("sh strobe", g_strb, 4'b1100);
    check("sh data", g_wd, 32'hABCDABCD);
    access(1, 3'b001, 32'h00000002, 32'h0, 32'hABCD0000,
           1, 2, -1, g_ld, g_addr, g_strb, g_wd);
    check("lh data", g_ld, 32'hFFFFABCD);

    access(0, 3'b000, 32'h00000101, 32'h000000A5, 32'h0,
           0, 0, -1, g_ld, g_addr, g_strb, g_wd);
    check("sb strobe", g_strb, 4'b0010);
    check("sb data", g_wd, 32'hA5A5A5A5);
    check("ld held after store", g_ld, 32'hFFFFABCD);
    access(1, 3'b101, 32'h00000200, 32'h0, 32'h1234F00D,
           0, 1, -1, g_ld, g_addr, g_strb, g_wd);
    check("lhu data", g_ld, 32'h0000F00D);
    access(1, 3'b010, 32'h00000300, 32'h0, 32'hCAFEF00D,
           1, 1, -1, g_ld, g_addr, g_strb, g_wd);
    check("lw data", g_ld, 32'hCAFEF00D);

    // timeout, then response on the limit cycle
    access(1, 3'b010, 32'h00000040, 32'h0, 32'h11111111,
           -1, -1, -1, g_ld, g_addr, g_strb, g_wd);
    check("timeout keeps ld", g_ld, 32'hCAFEF00D);
    access(1, 3'b010, 32'h00000044, 32'h0, 32'h22222222,
           0, 3, -1, g_ld, g_addr, g_strb, g_wd);
    check("limit wait resp", g_ld, 32'h22222222);
    access(0, 3'b010, 32'h00000048, 32'h33333333, 32'h0,
           3, 3, -1, g_ld, g_addr, g_strb, g_wd);

    // misaligned: no stall, no bus activity
    load_s1 = 1; misaligned_load_s1 = 1;
    e_stall = 0; e_rreq = 0; e_wreq = 0;
    repeat (3) begin @(posedge clock); #1; end
    load_s1 = 0; misaligned_load_s1 = 0;
    store_s1 = 1; misaligned_store_s1 = 1;
    repeat (2) begin @(posedge clock); #1; end
    store_s1 = 0; misaligned_store_s1 = 0;

    // flush during WAIT cancels the completion pulse
    access(1, 3'b010, 32'h00000010, 32'h0, 32'h44444444,
           0, 3, 1, g_ld, g_addr, g_strb, g_wd);
    check("flushed ld held", g_ld, 32'h22222222);

    // reset while waiting for a response
    load_s1 = 1; funct3_s1 = 3'b010;
    target_address_s1 = 32'h00000080; bus_read_data = 32'h55555555;
    e_stall = 1;
    @(posedge clock); #1;
    bus_ready = 1; e_rreq = 1; e_lanes = 1;
    e_addr = 32'h00000080;
    @(posedge clock); #1;
    bus_ready = 0; load_s1 = 0; e_rreq = 0; e_lanes = 0;
    reset_n = 0;
    @(posedge clock); #1;
    reset_n = 1; bus_response = 1;
    e_stall = 0; e_ld = '0;
    check("rst bus_address", bus_address, 32'h0);
    check("rst write_data", bus_write_data, 32'h0);
    @(posedge clock); #1;
    bus_response = 0;
    repeat (2) begin @(posedge clock); #1; end
    check("late resp no ld", load_data, 32'h0);

    chk_en = 0;
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_checks, n_fail);
    $finish;
  end

endmodule
